dma_cfg_slave_mc: RTL and testbench

Multi-channel DMA configuration slave on the AXI slave port. It holds per-channel source, destination and quantity registers, and issues per-channel start pulses to the DMA engine. It tracks per-channel busy/done status and raises a level interrupt. Unlike the single-channel version, it supports read-back, write strobes, INCR bursts, a channel-indexed address map and error responses.

---
 rtl/dma_cfg_slave_mc.sv | 273 +++++++++++++++++++++++++++
 tb/tb_dma_cfg_slave_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cfg_slave_mc.sv
// Multi-channel DMA configuration slave: per-channel SRC/DST/QTY/CTRL/STATUS/IRQ_EN registers behind an AXI slave port.
// Latency: W beat -> register visible next cycle; last W -> bvalid next cycle; AR -> first rvalid next cycle.
// Backpressure: one transaction at a time; wready/rvalid held in the data phase, bvalid held until bready.
//
// Ports: clk/rst (async, active-high); AXI AW/W/B/AR/R channels (INCR bursts of 4-byte beats);
// dma_fin_i per-channel completion in; dma_en_o per-channel start pulse out;
// src_addr_o/dst_addr_o/data_qty_o packed per-channel registers; irq_o level interrupt.
module dma_cfg_slave_mc #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          awid,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic [LEN_W-1:0]         awlen,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_W-1:0]          bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ID_W-1:0]          arid,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic [LEN_W-1:0]         arlen,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_W-1:0]          rid,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic [NUM_CH-1:0]        dma_fin_i,
  output logic [NUM_CH-1:0]        dma_en_o,
  output logic [NUM_CH*ADDR_W-1:0] src_addr_o,
  output logic [NUM_CH*ADDR_W-1:0] dst_addr_o,
  output logic [NUM_CH*ADDR_W-1:0] data_qty_o,
  output logic                     irq_o
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int STRB_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, W_CH, B_CH, R_CH} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [CH_BITS-1:0] ch_q, ch_d;
  logic [2:0]         word_q, word_d;
  logic               dec_q, dec_d;   // address outside the populated channels
  logic               slv_q, slv_d;   // a start was rejected during this burst

  logic [ADDR_W-1:0]  src_q [NUM_CH];
  logic [ADDR_W-1:0]  src_d [NUM_CH];
  logic [ADDR_W-1:0]  dst_q [NUM_CH];
  logic [ADDR_W-1:0]  dst_d [NUM_CH];
  logic [ADDR_W-1:0]  qty_q [NUM_CH];
  logic [ADDR_W-1:0]  qty_d [NUM_CH];
  logic [NUM_CH-1:0]  busy_q, busy_d, done_q, done_d;
  logic [NUM_CH-1:0]  irq_en_q, irq_en_d, dma_en_q, dma_en_d;
  logic               irq_q, irq_d;

  logic               wbeat;
  logic [DATA_W-1:0]  rd_word;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};
  assign wbeat = (state_q == W_CH) && wvalid;

  // Any set bit above the channel field also counts as an unpopulated channel,
  // so e.g. channel 7 does not alias onto channel 3 when NUM_CH = 4.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [31:0] ch;
    ch = 32'(a[5+CH_BITS-1:5]);
    return (a[ADDR_W-1:5+CH_BITS] != '0) || (ch >= 32'(NUM_CH));
  endfunction

  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Transaction FSM and captured burst context.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    word_d  = word_q;
    dec_d   = dec_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        awready = ~rst;
        arready = ~rst & ~awvalid;   // writes win a tie
        if (awvalid) begin
          state_d = W_CH;
          id_d    = awid;
          len_d   = awlen;
          cnt_d   = '0;
          ch_d    = awaddr[5+CH_BITS-1:5];
          word_d  = awaddr[4:2];
          dec_d   = addr_bad(awaddr);
        end else if (arvalid) begin
          state_d = R_CH;
          id_d    = arid;
          len_d   = arlen;
          cnt_d   = '0;
          ch_d    = araddr[5+CH_BITS-1:5];
          word_d  = araddr[4:2];
          dec_d   = addr_bad(araddr);
        end
      end
      W_CH: begin
        wready = 1'b1;
        if (wvalid) begin
          word_d = word_q + 3'd1;
          if (wlast) state_d = B_CH;
        end
      end
      B_CH: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      R_CH: begin
        rvalid = 1'b1;
        if (rready) begin
          word_d = word_q + 3'd1;
          cnt_d  = cnt_q + LEN_W'(1);
          if (cnt_q == len_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file, start/complete bookkeeping.
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    qty_d    = qty_q;
    busy_d   = busy_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    dma_en_d = '0;
    slv_d    = slv_q;
    if ((state_q == IDLE) && awvalid) slv_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wbeat && !dec_q && (ch_q == CH_BITS'(c))) begin
        case (word_q)
          3'd0: src_d[c] = strb_merge(src_q[c], wdata, wstrb);
          3'd1: dst_d[c] = strb_merge(dst_q[c], wdata, wstrb);
          3'd2: qty_d[c] = strb_merge(qty_q[c], wdata, wstrb);
          3'd4: if (wstrb[0] && wdata[1]) done_d[c] = 1'b0;
          3'd5: if (wstrb[0]) irq_en_d[c] = wdata[0];
          default: ;
        endcase
      end
      // Completion after W1C (done survives a coinciding clear) but before
      // start (an accepted start leaves busy=1, done=0).
      if (dma_fin_i[c]) begin
        busy_d[c] = 1'b0;
        done_d[c] = 1'b1;
      end
      if (wbeat && !dec_q && (ch_q == CH_BITS'(c)) && (word_q == 3'd3) && wstrb[0] && wdata[0]) begin
        if (busy_q[c]) begin
          slv_d = 1'b1;
        end else begin
          busy_d[c]   = 1'b1;
          done_d[c]   = 1'b0;
          dma_en_d[c] = 1'b1;
        end
      end
    end
    irq_d = |(done_q & irq_en_q);
  end

  // Read data is taken straight from the registers at the current word pointer.
  always_comb begin
    rd_word = '0;
    if ((state_q == R_CH) && !dec_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_q == CH_BITS'(c)) begin
          case (word_q)
            3'd0: rd_word = src_q[c];
            3'd1: rd_word = dst_q[c];
            3'd2: rd_word = qty_q[c];
            3'd4: rd_word = {{(DATA_W-2){1'b0}}, done_q[c], busy_q[c]};
            3'd5: rd_word = {{(DATA_W-1){1'b0}}, irq_en_q[c]};
            default: rd_word = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ch_q     <= '0;
      word_q   <= '0;
      dec_q    <= 1'b0;
      slv_q    <= 1'b0;
      busy_q   <= '0;
      done_q   <= '0;
      irq_en_q <= '0;
      dma_en_q <= '0;
      irq_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        qty_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      word_q   <= word_d;
      dec_q    <= dec_d;
      slv_q    <= slv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      dma_en_q <= dma_en_d;
      irq_q    <= irq_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      qty_q    <= qty_d;
    end
  end

  assign bid   = id_q;
  assign rid   = id_q;
  assign bresp = (state_q != B_CH) ? 2'b00 : dec_q ? 2'b11 : slv_q ? 2'b10 : 2'b00;
  assign rresp = ((state_q == R_CH) && dec_q) ? 2'b11 : 2'b00;
  assign rlast = (state_q == R_CH) && (cnt_q == len_q);
  assign rdata = rd_word;
  assign dma_en_o = dma_en_q;
  assign irq_o    = irq_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign src_addr_o[g*ADDR_W +: ADDR_W] = src_q[g];
    assign dst_addr_o[g*ADDR_W +: ADDR_W] = dst_q[g];
    assign data_qty_o[g*ADDR_W +: ADDR_W] = qty_q[g];
  end

endmodule

// File: tb/tb_dma_cfg_slave_mc.sv
// Directed bench for dma_cfg_slave_mc: register config, strobes, busy/done/irq,
// decode errors, write-before-read arbitration, read wrap and mid-burst reset.
module tb_dma_cfg_slave_mc;
  localparam int NUM_CH = 4;

  logic         clk, rst;
  logic [7:0]   awid, arid, bid, rid;
  logic [31:0]  awaddr, araddr, wdata, rdata;
  logic [3:0]   awlen, arlen, wstrb;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready, irq_o;
  logic [1:0]   bresp, rresp;
  logic [NUM_CH-1:0]    dma_fin_i, dma_en_o;
  logic [NUM_CH*32-1:0] src_addr_o, dst_addr_o, data_qty_o;

  dma_cfg_slave_mc #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dma_fin_i(dma_fin_i), .dma_en_o(dma_en_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .data_qty_o(data_qty_o),
    .irq_o(irq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  int pulse_cnt = 0;
  int snap;
  logic [NUM_CH-1:0] last_en = '0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [1:0]  b_resp;
  logic [7:0]  b_id, r_id;
  logic [31:0] exp_burst [10];

  // Start-pulse monitor: counts cycles with any dma_en_o bit set.
  always @(negedge clk) begin
    if (dma_en_o != '0) begin
      pulse_cnt++;
      last_en = dma_en_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [7:0] id,
                           input logic [NUM_CH-1:0] fin_last);
    int n;
    awaddr = addr; awlen = len[3:0]; awid = id; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    chk("aw_wait", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len); wvalid = 1'b1;
      if (i == len) dma_fin_i = fin_last;
      #1;
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      tick();
      dma_fin_i = '0;
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("b_wait", bvalid, 1);
    b_resp = bresp; b_id = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [7:0] id);
    int n;
    araddr = addr; arlen = len[3:0]; arid = id; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    chk("ar_wait", arready, 1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      rd[i] = rdata; rr[i] = rresp; rl[i] = rlast; r_id = rid;
      tick();
    end
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    dma_fin_i = '0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_dma_en", dma_en_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_src", src_addr_o, 0);
    rst = 1'b0;
    #1;
    chk("idle_awready", awready, 1);
    chk("idle_arready", arready, 1);

    // Channel 2 configuration and start
    wd[0] = 32'h1000_0000; wd[1] = 32'h2000_0000; wd[2] = 32'h0000_0040;
    axi_write(32'h40, 2, 8'h11, '0);
    chk("ch2_cfg_bresp", b_resp, 2'b00);
    chk("ch2_cfg_bid", b_id, 8'h11);
    snap = pulse_cnt;
    wd[0] = 32'h1;
    axi_write(32'h4C, 0, 8'h12, '0);
    chk("ch2_start_bresp", b_resp, 2'b00);
    chk("ch2_pulse_cycles", pulse_cnt - snap, 1);
    chk("ch2_pulse_vec", last_en, 4'b0100);
    axi_read(32'h50, 0, 8'h5A);
    chk("ch2_status", rd[0], 32'h1);
    chk("ch2_status_rresp", rr[0], 2'b00);
    chk("ch2_rid", r_id, 8'h5A);
    chk("ch2_src_o", src_addr_o[2*32 +: 32], 32'h1000_0000);
    chk("ch2_dst_o", dst_addr_o[2*32 +: 32], 32'h2000_0000);
    chk("ch2_qty_o", data_qty_o[2*32 +: 32], 32'h40);

    // Channel 0 burst with a partial strobe on DST
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333; wd[3] = 32'h1;
    ws[1] = 4'b0011;
    snap = pulse_cnt;
    axi_write(32'h00, 3, 8'h22, '0);
    ws[1] = 4'hF;
    chk("ch0_burst_bresp", b_resp, 2'b00);
    chk("ch0_pulse_cycles", pulse_cnt - snap, 1);
    chk("ch0_pulse_vec", last_en, 4'b0001);
    chk("ch0_src_o", src_addr_o[0 +: 32], 32'h1111_1111);
    chk("ch0_dst_strb", dst_addr_o[0 +: 32], 32'h0000_2222);
    chk("ch0_qty_o", data_qty_o[0 +: 32], 32'h3333_3333);

    // Channel 1: start, start-while-busy, completion, irq, W1C races
    wd[0] = 32'h1;
    snap = pulse_cnt;
    axi_write(32'h2C, 0, 8'h30, '0);
    chk("ch1_start_bresp", b_resp, 2'b00);
    chk("ch1_start_pulse", pulse_cnt - snap, 1);
    snap = pulse_cnt;
    axi_write(32'h2C, 0, 8'h31, '0);
    chk("busy_start_bresp", b_resp, 2'b10);
    chk("busy_start_pulse", pulse_cnt - snap, 0);
    dma_fin_i = 4'b0010;
    tick();
    dma_fin_i = '0;
    axi_read(32'h30, 0, 8'h32);
    chk("ch1_done_status", rd[0], 32'h2);
    wd[0] = 32'h1;
    axi_write(32'h34, 0, 8'h33, '0);
    chk("irq_en_bresp", b_resp, 2'b00);
    tick(); tick();
    chk("irq_set", irq_o, 1);
    wd[0] = 32'h2;
    axi_write(32'h30, 0, 8'h34, 4'b0010);
    axi_read(32'h30, 0, 8'h35);
    chk("w1c_vs_fin_status", rd[0], 32'h2);
    wd[0] = 32'h1;
    snap = pulse_cnt;
    axi_write(32'h2C, 0, 8'h36, 4'b0010);
    chk("start_vs_fin_bresp", b_resp, 2'b00);
    chk("start_vs_fin_pulse", pulse_cnt - snap, 1);
    axi_read(32'h30, 0, 8'h37);
    chk("start_vs_fin_status", rd[0], 32'h1);
    dma_fin_i = 4'b0010;
    tick();
    dma_fin_i = '0;
    wd[0] = 32'h2;
    axi_write(32'h30, 0, 8'h38, '0);
    axi_read(32'h30, 0, 8'h39);
    chk("w1c_status", rd[0], 32'h0);
    tick(); tick();
    chk("irq_cleared", irq_o, 0);

    // Unpopulated channel 7
    axi_read(32'hE0, 1, 8'h40);
    chk("dec_rd0", rd[0], 32'h0);
    chk("dec_rd1", rd[1], 32'h0);
    chk("dec_rresp0", rr[0], 2'b11);
    chk("dec_rresp1", rr[1], 2'b11);
    chk("dec_rlast0", rl[0], 0);
    chk("dec_rlast1", rl[1], 1);
    wd[0] = 32'hDEAD_BEEF;
    axi_write(32'hE0, 0, 8'h41, '0);
    chk("dec_bresp", b_resp, 2'b11);
    chk("dec_no_write", src_addr_o, {32'h0, 32'h1000_0000, 32'h0, 32'h1111_1111});

    // Simultaneous AW and AR: write first
    awaddr = 32'h60; awlen = '0; awid = 8'h44; awvalid = 1'b1;
    araddr = 32'h60; arlen = '0; arid = 8'h55; arvalid = 1'b1;
    #1;
    chk("tie_awready", awready, 1);
    chk("tie_arready", arready, 0);
    tick();
    awvalid = 1'b0;
    #1;
    chk("tie_wready", wready, 1);
    chk("tie_arready_w", arready, 0);
    wdata = 32'hABCD_0123; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("tie_bvalid", bvalid, 1);
    chk("tie_arready_b", arready, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #1;
    chk("tie_arready_idle", arready, 1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    #1;
    chk("tie_rvalid", rvalid, 1);
    chk("tie_rdata", rdata, 32'hABCD_0123);
    chk("tie_rid", rid, 8'h55);
    chk("tie_rlast", rlast, 1);
    tick();
    rready = 1'b0;
    #1;
    chk("tie_rvalid_done", rvalid, 0);

    // Read burst of 10 beats wraps after word 7
    exp_burst[0] = 32'h1000_0000; exp_burst[1] = 32'h2000_0000; exp_burst[2] = 32'h40;
    exp_burst[3] = 32'h0;         exp_burst[4] = 32'h1;         exp_burst[5] = 32'h0;
    exp_burst[6] = 32'h0;         exp_burst[7] = 32'h0;
    exp_burst[8] = 32'h1000_0000; exp_burst[9] = 32'h2000_0000;
    axi_read(32'h40, 9, 8'h60);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap_rd%0d", i), rd[i], exp_burst[i]);
      chk($sformatf("wrap_rlast%0d", i), rl[i], (i == 9));
    end

    // Reset in the middle of a write burst
    awaddr = 32'h60; awlen = 4'd3; awid = 8'h70; awvalid = 1'b1;
    #1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h5555_5555; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wready", wready, 0);
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_src", src_addr_o, 0);
    chk("mid_rst_dst", dst_addr_o, 0);
    wvalid = 1'b0;
    tick();
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_dma_en", dma_en_o, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 0);
    repeat (3) tick();
    chk("post_rst_no_b", bvalid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
